// File: rtl/gat_bram_loader.sv
// gat_bram_loader: takes a word stream and writes it into four BRAM regions
// in a fixed order (H data, node info, weights, subgraph index). Each accepted
// beat becomes one registered write strobe on the next cycle, at a byte address.
// Optional feature macro: GAT_LOADER_LEN_CHECK_EN. When it is defined, s_last
// ends a region early, and any region length mismatch sets the sticky load_err.
module gat_bram_loader #(
    parameter int TOP_WIDTH       = 32,
    parameter int H_DATA_DEPTH    = 242101,
    parameter int NODE_INFO_DEPTH = 13264,
    parameter int WEIGHT_DEPTH    = 22928,
    parameter int SUBGRAPH_DEPTH  = 13264,
    localparam int H_AW  = $clog2(H_DATA_DEPTH),
    localparam int NI_AW = $clog2(NODE_INFO_DEPTH),
    localparam int W_AW  = $clog2(WEIGHT_DEPTH),
    localparam int SG_AW = $clog2(SUBGRAPH_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [TOP_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [TOP_WIDTH-1:0] h_data_bram_din,
    output logic                 h_data_bram_ena,
    output logic                 h_data_bram_wea,
    output logic [H_AW+1:0]      h_data_bram_addra,
    output logic [TOP_WIDTH-1:0] h_node_info_bram_din,
    output logic                 h_node_info_bram_ena,
    output logic                 h_node_info_bram_wea,
    output logic [NI_AW+1:0]     h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0] wgt_bram_din,
    output logic                 wgt_bram_ena,
    output logic                 wgt_bram_wea,
    output logic [W_AW+1:0]      wgt_bram_addra,
    output logic [TOP_WIDTH-1:0] subgraph_bram_din,
    output logic                 subgraph_bram_ena,
    output logic                 subgraph_bram_wea,
    output logic [SG_AW+1:0]     subgraph_bram_addra,
    output logic                 h_data_bram_load_done,
    output logic                 h_node_info_bram_load_done,
    output logic                 wgt_bram_load_done,
    output logic                 subgraph_bram_load_done,
    output logic                 busy,
    output logic                 load_err
);

    typedef enum logic [2:0] {IDLE, LOAD_H, LOAD_NI, LOAD_W, LOAD_SG, DONE} state_t;

    // One shared word counter, wide enough for the largest region.
    localparam int IDX_W_HN = (H_AW > NI_AW) ? H_AW : NI_AW;
    localparam int IDX_W_WS = (W_AW > SG_AW) ? W_AW : SG_AW;
    localparam int IDX_W    = (IDX_W_HN > IDX_W_WS) ? IDX_W_HN : IDX_W_WS;

    localparam logic [IDX_W-1:0] H_LAST  = IDX_W'(H_DATA_DEPTH - 1);
    localparam logic [IDX_W-1:0] NI_LAST = IDX_W'(NODE_INFO_DEPTH - 1);
    localparam logic [IDX_W-1:0] W_LAST  = IDX_W'(WEIGHT_DEPTH - 1);
    localparam logic [IDX_W-1:0] SG_LAST = IDX_W'(SUBGRAPH_DEPTH - 1);

    state_t               state_q, state_d, next_region;
    logic [IDX_W-1:0]     idx_q, idx_d, last_idx;
    logic                 s_ready_q, s_ready_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [3:0]           wr_q, wr_d;     // write strobe per region {sg, w, ni, h}
    logic [3:0]           fin_q, fin_d;   // that strobe is the region's final write
    logic [3:0]           done_q, done_d;
    logic [TOP_WIDTH-1:0] h_din_q, h_din_d, ni_din_q, ni_din_d;
    logic [TOP_WIDTH-1:0] w_din_q, w_din_d, sg_din_q, sg_din_d;
    logic [H_AW+1:0]      h_addr_q, h_addr_d;
    logic [NI_AW+1:0]     ni_addr_q, ni_addr_d;
    logic [W_AW+1:0]      w_addr_q, w_addr_d;
    logic [SG_AW+1:0]     sg_addr_q, sg_addr_d;
    logic                 accept, at_last, end_region;

`ifndef GAT_LOADER_LEN_CHECK_EN
    // Count-only termination: s_last has no meaning here.
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    // Next-state, write-port and flag computation for the load sequence.
    always_comb begin
        // NOTE: every signal gets its default first, so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        wr_d        = '0;
        fin_d       = '0;
        done_d      = done_q | fin_q;
        h_din_d     = h_din_q;
        ni_din_d    = ni_din_q;
        w_din_d     = w_din_q;
        sg_din_d    = sg_din_q;
        h_addr_d    = h_addr_q;
        ni_addr_d   = ni_addr_q;
        w_addr_d    = w_addr_q;
        sg_addr_d   = sg_addr_q;
        last_idx    = '0;
        next_region = DONE;
        accept      = s_valid && s_ready_q;

        case (state_q)
            LOAD_H:  begin last_idx = H_LAST;  next_region = LOAD_NI; end
            LOAD_NI: begin last_idx = NI_LAST; next_region = LOAD_W;  end
            LOAD_W:  begin last_idx = W_LAST;  next_region = LOAD_SG; end
            LOAD_SG: begin last_idx = SG_LAST; next_region = DONE;    end
            default: ;
        endcase

        at_last = (idx_q == last_idx);
`ifdef GAT_LOADER_LEN_CHECK_EN
        end_region = at_last || s_last;
`else
        end_region = at_last;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD_H;
                    idx_d   = '0;
                    done_d  = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD_H: if (accept) begin
                wr_d[0]  = 1'b1;
                h_din_d  = s_data;
                h_addr_d = {idx_q[H_AW-1:0], 2'b00};
            end
            LOAD_NI: if (accept) begin
                wr_d[1]   = 1'b1;
                ni_din_d  = s_data;
                ni_addr_d = {idx_q[NI_AW-1:0], 2'b00};
            end
            LOAD_W: if (accept) begin
                wr_d[2]  = 1'b1;
                w_din_d  = s_data;
                w_addr_d = {idx_q[W_AW-1:0], 2'b00};
            end
            LOAD_SG: if (accept) begin
                wr_d[3]   = 1'b1;
                sg_din_d  = s_data;
                sg_addr_d = {idx_q[SG_AW-1:0], 2'b00};
            end
            default: state_d = IDLE;
        endcase

        // accept is only possible in a LOAD_* state, where s_ready is high.
        if (accept) begin
            if (end_region) begin
                state_d = next_region;
                idx_d   = '0;
                fin_d   = wr_d;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
`ifdef GAT_LOADER_LEN_CHECK_EN
            if (at_last != s_last) begin
                err_d = 1'b1;
            end
`endif
        end

        s_ready_d = (state_d == LOAD_H) || (state_d == LOAD_NI) ||
                    (state_d == LOAD_W) || (state_d == LOAD_SG);
        busy_d    = s_ready_d;
    end

    // State and registered outputs, synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_q      <= '0;
            fin_q     <= '0;
            done_q    <= '0;
            h_din_q   <= '0;
            ni_din_q  <= '0;
            w_din_q   <= '0;
            sg_din_q  <= '0;
            h_addr_q  <= '0;
            ni_addr_q <= '0;
            w_addr_q  <= '0;
            sg_addr_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q   <= state_d;
            idx_q     <= idx_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            wr_q      <= wr_d;
            fin_q     <= fin_d;
            done_q    <= done_d;
            h_din_q   <= h_din_d;
            ni_din_q  <= ni_din_d;
            w_din_q   <= w_din_d;
            sg_din_q  <= sg_din_d;
            h_addr_q  <= h_addr_d;
            ni_addr_q <= ni_addr_d;
            w_addr_q  <= w_addr_d;
            sg_addr_q <= sg_addr_d;
        end
    end

    assign s_ready                    = s_ready_q;
    assign busy                       = busy_q;
    assign load_err                   = err_q;
    assign h_data_bram_din            = h_din_q;
    assign h_data_bram_ena            = wr_q[0];
    assign h_data_bram_wea            = wr_q[0];
    assign h_data_bram_addra          = h_addr_q;
    assign h_node_info_bram_din       = ni_din_q;
    assign h_node_info_bram_ena       = wr_q[1];
    assign h_node_info_bram_wea       = wr_q[1];
    assign h_node_info_bram_addra     = ni_addr_q;
    assign wgt_bram_din               = w_din_q;
    assign wgt_bram_ena               = wr_q[2];
    assign wgt_bram_wea               = wr_q[2];
    assign wgt_bram_addra             = w_addr_q;
    assign subgraph_bram_din          = sg_din_q;
    assign subgraph_bram_ena          = wr_q[3];
    assign subgraph_bram_wea          = wr_q[3];
    assign subgraph_bram_addra        = sg_addr_q;
    assign h_data_bram_load_done      = done_q[0];
    assign h_node_info_bram_load_done = done_q[1];
    assign wgt_bram_load_done         = done_q[2];
    assign subgraph_bram_load_done    = done_q[3];

endmodule

// File: tb/tb_gat_bram_loader.sv
// Self-checking bench for gat_bram_loader with small regions (H=4, NI=3, W=2, SG=2).
// Expected write logs come from a region-walk model over the beats the bench sent.
module tb_gat_bram_loader;

    localparam int TW = 32;
    localparam int DEPTH [4] = '{4, 3, 2, 2};
`ifdef GAT_LOADER_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, s_valid, s_last;
    logic [TW-1:0] s_data;
    logic          s_ready, busy, load_err;
    logic [TW-1:0] h_din, ni_din, w_din, sg_din;
    logic          h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea, sg_ena, sg_wea;
    logic [3:0]    h_addr, ni_addr;
    logic [2:0]    w_addr, sg_addr;
    logic          h_done, ni_done, w_done, sg_done;

    gat_bram_loader #(
        .TOP_WIDTH(TW), .H_DATA_DEPTH(4), .NODE_INFO_DEPTH(3),
        .WEIGHT_DEPTH(2), .SUBGRAPH_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .h_data_bram_din(h_din), .h_data_bram_ena(h_ena),
        .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addr),
        .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena),
        .h_node_info_bram_wea(ni_wea), .h_node_info_bram_addra(ni_addr),
        .wgt_bram_din(w_din), .wgt_bram_ena(w_ena),
        .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addr),
        .subgraph_bram_din(sg_din), .subgraph_bram_ena(sg_ena),
        .subgraph_bram_wea(sg_wea), .subgraph_bram_addra(sg_addr),
        .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(ni_done),
        .wgt_bram_load_done(w_done), .subgraph_bram_load_done(sg_done),
        .busy(busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  region;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        int          mode;      // 0 always valid, 1 toggled, 2 random gaps
        logic [31:0] last_mask; // s_last on accepted beat k when bit k set
        bit          rnd_data;
        int          start_at;  // inject a start pulse before beat k (-1 none)
    } scen_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          strobe_err;
    wr_t         wr_log[$];
    int          acc_cyc[$];
    int          done_cyc[4];
    logic [3:0]  prev_done;
    logic [31:0] beat_data[32];
    int          exp_reg[32];
    int          exp_idx[32];
    int          exp_fin[4];
    bit          exp_err;
    int          exp_n;
    scen_t       scen[5];

    wire [3:0] done_v = {sg_done, w_done, ni_done, h_done};
    wire [3:0] ena_v  = {sg_ena, w_ena, ni_ena, h_ena};
    wire [3:0] wea_v  = {sg_wea, w_wea, ni_wea, h_wea};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: write log, accepted-beat cycles, first rise of each done flag.
    always @(negedge clk) begin
        if (ena_v != wea_v || $countones(ena_v) > 1) strobe_err++;
        if (h_ena)  wr_log.push_back({2'd0, 8'(h_addr),  h_din});
        if (ni_ena) wr_log.push_back({2'd1, 8'(ni_addr), ni_din});
        if (w_ena)  wr_log.push_back({2'd2, 8'(w_addr),  w_din});
        if (sg_ena) wr_log.push_back({2'd3, 8'(sg_addr), sg_din});
        if (s_valid && s_ready) acc_cyc.push_back(cyc);
        for (int r = 0; r < 4; r++)
            if (done_v[r] && !prev_done[r] && done_cyc[r] < 0) done_cyc[r] = cyc;
        prev_done = done_v;
    end

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk accepted beats through the regions in order.
    task automatic model_walk(input logic [31:0] mask);
        int  r = 0;
        int  i = 0;
        int  k = 0;
        bit  at_end;
        exp_err = 1'b0;
        while (r < 4 && k < 32) begin
            exp_reg[k] = r;
            exp_idx[k] = i;
            at_end = (i == DEPTH[r] - 1);
            if (CHK && (mask[k] != at_end)) exp_err = 1'b1;
            if (at_end || (CHK && mask[k])) begin
                exp_fin[r] = k;
                r++;
                i = 0;
            end else begin
                i++;
            end
            k++;
        end
        exp_n = k;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        acc_cyc.delete();
        strobe_err = 0;
        for (int r = 0; r < 4; r++) done_cyc[r] = -1;
    endtask

    task automatic do_start();
        start = 1'b1;
        to_pos();
        start = 1'b0;
    endtask

    // Offer n beats; valid-low cycles carry junk data and s_last=1 to prove they are ignored.
    task automatic send_beats(input int n, input int mode, input logic [31:0] mask, input int start_at);
        int k = 0;
        int guard = 0;
        bit pulsed = 1'b0;
        bit acc;
        bit want;
        while (k < n && guard < 400) begin
            guard++;
            if (k == start_at && !pulsed) begin
                pulsed  = 1'b1;
                s_valid = 1'b0;
                start   = 1'b1;
                to_pos();
                start = 1'b0;
                @(negedge clk);
                check("start_ignored_busy", 64'(busy), 64'd1);
                check("start_ignored_hdone", 64'(h_done), 64'd1);
                to_pos();
                continue;
            end
            case (mode)
                0:       want = 1'b1;
                1:       want = guard[0];
                default: want = ($urandom_range(0, 2) != 0);
            endcase
            s_valid = want;
            s_data  = want ? beat_data[k] : $urandom;
            s_last  = want ? mask[k] : 1'b1;
            @(negedge clk);
            acc = s_valid && s_ready;
            to_pos();
            if (acc) k++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("send_complete", 64'(k), 64'(n));
    endtask

    task automatic run_load(input scen_t sc);
        logic [63:0] act;
        logic [63:0] exp;
        for (int k = 0; k < 32; k++) beat_data[k] = sc.rnd_data ? $urandom : 32'h100 + 32'(k);
        model_walk(sc.last_mask);
        clear_logs();
        do_start();
        @(negedge clk);
        check({sc.name, "_flags_cleared"}, {59'd0, done_v, load_err}, 64'd0);
        check({sc.name, "_busy"}, 64'(busy), 64'd1);
        to_pos();
        send_beats(exp_n, sc.mode, sc.last_mask, sc.start_at);
        repeat (4) to_pos();
        @(negedge clk);
        check({sc.name, "_strobes"}, 64'(strobe_err), 64'd0);
        check({sc.name, "_nwrites"}, 64'(wr_log.size()), 64'(exp_n));
        for (int k = 0; k < exp_n; k++) begin
            act = (k < wr_log.size()) ? 64'(wr_log[k]) : '1;
            exp = 64'(wr_t'{2'(exp_reg[k]), 8'(exp_idx[k] * 4), beat_data[k]});
            check($sformatf("%s_write%0d", sc.name, k), act, exp);
        end
        for (int r = 0; r < 4; r++) begin
            act = (exp_fin[r] < acc_cyc.size()) ? 64'(done_cyc[r] - acc_cyc[exp_fin[r]]) : '1;
            check($sformatf("%s_done_lat%0d", sc.name, r), act, 64'd2);
        end
        if (sc.mode == 0 && sc.start_at < 0 && acc_cyc.size() == exp_n)
            check({sc.name, "_no_bubble"}, 64'(acc_cyc[exp_n-1] - acc_cyc[0]), 64'(exp_n - 1));
        check({sc.name, "_done_all"}, 64'(done_v), 64'hF);
        check({sc.name, "_load_err"}, 64'(load_err), 64'(exp_err));
        check({sc.name, "_idle_out"}, {62'd0, busy, s_ready}, 64'd0);
        to_pos();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctl"}, {49'd0, ena_v, wea_v, done_v, busy, load_err, s_ready}, 64'd0);
        check({name, "_din"}, {h_din, ni_din} | {w_din, sg_din}, 64'd0);
        check({name, "_addr"}, 64'({h_addr, ni_addr, w_addr, sg_addr}), 64'd0);
    endtask

    initial begin
        scen[0] = '{"b2b",       0, 32'h548, 1'b0, -1};
        scen[1] = '{"toggle",    1, 32'h548, 1'b0, -1};
        scen[2] = '{"early",     0, 32'h152, 1'b0, -1};
        scen[3] = '{"rand",      2, 32'h548, 1'b1, -1};
        scen[4] = '{"rand_gaps", 2, 32'h548, 1'b1, -1};
        prev_done = '0;
        clear_logs();
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        repeat (3) to_pos();
        @(negedge clk);
        check_reset_outputs("reset");
        to_pos();
        rst = 1'b0;
        to_pos();

        // Table of full-sequence scenarios, each from IDLE or DONE.
        for (int s = 0; s < 5; s++) run_load(scen[s]);

        // Reset mid-load after two H beats abandons the sequence.
        for (int k = 0; k < 32; k++) beat_data[k] = 32'h200 + 32'(k);
        clear_logs();
        do_start();
        send_beats(2, 0, 32'h0, -1);
        @(negedge clk);
        check("midrst_no_done", 64'(done_v), 64'd0);
        to_pos();
        rst = 1'b1;
        to_pos();
        @(negedge clk);
        check_reset_outputs("midrst");
        to_pos();
        rst = 1'b0;
        to_pos();
        run_load(scen[0]);

        // Start pulse while loading node info must not restart anything.
        run_load('{"start_in_ni", 0, 32'h548, 1'b0, 5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
